// File: rtl/div_seq.sv
// Sequential restoring divider: one (M+1)-bit conditional-subtract stage reused over N cycles,
// MSB first, with valid/ready handshakes on both the operand and the result side.
module div_seq #(
  parameter int unsigned N = 8,
  parameter int unsigned M = N
) (
  input  logic         clk_i,
  input  logic         rst_ni,
  input  logic         in_valid_i,
  output logic         in_ready_o,
  input  logic [N-1:0] a_i,
  input  logic [M-1:0] b_i,
  output logic         out_valid_o,
  input  logic         out_ready_i,
  output logic [N-1:0] q_o,
  output logic [M-1:0] r_o,
  output logic         dbz_o
);

  localparam int unsigned CntW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  state_e          state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [N-1:0]    quo_q, quo_d;
  logic [M-1:0]    rem_q, rem_d;
  logic [M-1:0]    den_q, den_d;
  logic            dbz_q, dbz_d;

  logic [M:0]      trial;
  logic            trial_ge;
  logic [M-1:0]    step_rem;
  logic [N-1:0]    step_quo;

  // Partial remainder stays below the divisor, so T - D always fits in M bits and only the
  // low M bits of the subtraction are needed.
  always_comb begin
    trial    = {rem_q, quo_q[N-1]};
    trial_ge = (trial >= {1'b0, den_q});
    step_rem = trial_ge ? (trial[M-1:0] - den_q) : trial[M-1:0];
    step_quo = {quo_q[N-2:0], trial_ge};
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    quo_d   = quo_q;
    rem_d   = rem_q;
    den_d   = den_q;
    dbz_d   = dbz_q;
    unique case (state_q)
      StIdle: begin
        if (in_valid_i) begin
          quo_d   = a_i;
          den_d   = b_i;
          rem_d   = '0;
          cnt_d   = CntW'(N - 1);
          dbz_d   = (b_i == '0);
          state_d = StRun;
        end
      end
      StRun: begin
        quo_d = step_quo;
        rem_d = step_rem;
        if (cnt_q == '0) begin
          state_d = StDone;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StDone: begin
        if (out_ready_i) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      quo_q   <= '0;
      rem_q   <= '0;
      den_q   <= '0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      quo_q   <= quo_d;
      rem_q   <= rem_d;
      den_q   <= den_d;
      dbz_q   <= dbz_d;
    end
  end

  assign in_ready_o  = (state_q == StIdle);
  assign out_valid_o = (state_q == StDone);
  assign q_o         = quo_q;
  assign r_o         = rem_q;
  assign dbz_o       = dbz_q;

endmodule

// File: tb/tb_div_seq.sv
// Self-checking bench for div_seq: three instances (8/8, 16/8, 8/4) driven one at a time,
// expected results queued at stimulus time and popped when the result handshake appears.
module tb_div_seq;

  typedef struct packed {
    logic [15:0] q;
    logic [7:0]  r;
    logic        dbz;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  sel;
  logic        in_valid, out_ready;
  logic [15:0] a;
  logic [7:0]  b;

  logic        rdy0, rdy1, rdy2, vld0, vld1, vld2, dbz0, dbz1, dbz2;
  logic [7:0]  q0, r0, r1, q2;
  logic [15:0] q1;
  logic [3:0]  r2;

  logic        cur_in_ready, cur_out_valid, cur_dbz;
  logic [15:0] cur_q;
  logic [7:0]  cur_r;

  int   n_checks = 0;
  int   n_errors = 0;
  exp_t exp_q[$];

  always #5 clk = ~clk;

  div_seq #(.N(8), .M(8)) u_dut0 (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid && sel == 2'd0), .in_ready_o(rdy0),
    .a_i(a[7:0]), .b_i(b), .out_valid_o(vld0), .out_ready_i(out_ready && sel == 2'd0),
    .q_o(q0), .r_o(r0), .dbz_o(dbz0)
  );

  div_seq #(.N(16), .M(8)) u_dut1 (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid && sel == 2'd1), .in_ready_o(rdy1),
    .a_i(a), .b_i(b), .out_valid_o(vld1), .out_ready_i(out_ready && sel == 2'd1),
    .q_o(q1), .r_o(r1), .dbz_o(dbz1)
  );

  div_seq #(.N(8), .M(4)) u_dut2 (
    .clk_i(clk), .rst_ni(rst_n), .in_valid_i(in_valid && sel == 2'd2), .in_ready_o(rdy2),
    .a_i(a[7:0]), .b_i(b[3:0]), .out_valid_o(vld2), .out_ready_i(out_ready && sel == 2'd2),
    .q_o(q2), .r_o(r2), .dbz_o(dbz2)
  );

  always_comb begin
    cur_in_ready  = rdy0;
    cur_out_valid = vld0;
    cur_q         = {8'h00, q0};
    cur_r         = r0;
    cur_dbz       = dbz0;
    case (sel)
      2'd1: begin
        cur_in_ready = rdy1; cur_out_valid = vld1; cur_q = q1; cur_r = r1; cur_dbz = dbz1;
      end
      2'd2: begin
        cur_in_ready = rdy2; cur_out_valid = vld2; cur_q = {8'h00, q2};
        cur_r = {4'h0, r2}; cur_dbz = dbz2;
      end
      default: ;
    endcase
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got !== want) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    end
  endtask

  function automatic int unsigned width_n(input logic [1:0] s);
    return (s == 2'd1) ? 16 : 8;
  endfunction

  // Reference: a/b and a%b, or all-ones quotient with the low M dividend bits when b == 0.
  function automatic exp_t model(input logic [1:0] s, input logic [15:0] av, input logic [7:0] bv);
    int unsigned n, m, am, bm;
    exp_t e;
    n  = width_n(s);
    m  = (s == 2'd2) ? 4 : 8;
    am = 32'(av) & ((32'h1 << n) - 1);
    bm = 32'(bv) & ((32'h1 << m) - 1);
    if (bm == 0) begin
      e.q   = 16'((32'h1 << n) - 1);
      e.r   = 8'(am & ((32'h1 << m) - 1));
      e.dbz = 1'b1;
    end else begin
      e.q   = 16'(am / bm);
      e.r   = 8'(am % bm);
      e.dbz = 1'b0;
    end
    return e;
  endfunction

  // Called at a negedge with the selected instance idle.
  task automatic do_op(input logic [15:0] av, input logic [7:0] bv, input int hold);
    int   cyc;
    exp_t e;
    exp_t got;
    logic [15:0] q_hold;
    logic [7:0]  r_hold;
    logic        d_hold;
    exp_q.push_back(model(sel, av, bv));
    check_eq("in_ready_idle", 32'(cur_in_ready), 32'd1);
    a = av; b = bv; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    cyc = 0;
    while (!cur_out_valid && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    check_eq("latency", 32'(cyc), width_n(sel));
    e = exp_q.pop_front();
    got.q = cur_q; got.r = cur_r; got.dbz = cur_dbz;
    check_eq("q", 32'(got.q), 32'(e.q));
    check_eq("r", 32'(got.r), 32'(e.r));
    check_eq("dbz", 32'(got.dbz), 32'(e.dbz));
    q_hold = cur_q; r_hold = cur_r; d_hold = cur_dbz;
    for (int i = 0; i < hold; i++) begin
      a = 16'h0009; b = 8'h02; in_valid = 1'b1;
      @(negedge clk);
      check_eq("hold_valid", 32'(cur_out_valid), 32'd1);
      check_eq("hold_in_ready", 32'(cur_in_ready), 32'd0);
      check_eq("hold_q", 32'(cur_q), 32'(q_hold));
      check_eq("hold_r", 32'(cur_r), 32'(r_hold));
      check_eq("hold_dbz", 32'(cur_dbz), 32'(d_hold));
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check_eq("post_idle_ready", 32'(cur_in_ready), 32'd1);
    check_eq("post_idle_valid", 32'(cur_out_valid), 32'd0);
  endtask

  initial begin
    int t_first, t_second, cyc;
    exp_t e;
    rst_n = 1'b0; sel = 2'd0; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int s = 0; s < 3; s++) begin
      sel = 2'(s);
      #0;
      check_eq("rst_in_ready", 32'(cur_in_ready), 32'd1);
      check_eq("rst_out_valid", 32'(cur_out_valid), 32'd0);
      check_eq("rst_q", 32'(cur_q), 32'd0);
      check_eq("rst_r", 32'(cur_r), 32'd0);
      check_eq("rst_dbz", 32'(cur_dbz), 32'd0);
    end

    sel = 2'd0;
    do_op(16'd100, 8'd7, 0);
    do_op(16'd255, 8'd1, 0);
    do_op(16'd5, 8'd9, 0);
    do_op(16'd0, 8'd3, 0);
    do_op(16'd200, 8'd0, 0);
    do_op(16'd123, 8'd10, 5);

    sel = 2'd2;
    do_op(16'h00B7, 8'h00, 0);
    do_op(16'd200, 8'd13, 0);
    sel = 2'd0;

    // Back-to-back with out_ready and in_valid held high: one result every N+2 cycles.
    exp_q.push_back(model(sel, 16'd50, 8'd6));
    exp_q.push_back(model(sel, 16'd50, 8'd6));
    a = 16'd50; b = 8'd6; in_valid = 1'b1; out_ready = 1'b1;
    t_first = -1; t_second = -1; cyc = 0;
    while (t_second < 0 && cyc < 60) begin
      @(negedge clk);
      cyc++;
      if (cur_out_valid) begin
        e = exp_q.pop_front();
        check_eq("b2b_q", 32'(cur_q), 32'(e.q));
        check_eq("b2b_r", 32'(cur_r), 32'(e.r));
        if (t_first < 0) t_first = cyc;
        else begin
          t_second = cyc;
          in_valid = 1'b0;
        end
      end
    end
    check_eq("b2b_period", 32'(t_second - t_first), 32'd10);
    in_valid = 1'b0;
    @(negedge clk);
    out_ready = 1'b0;
    check_eq("b2b_idle", 32'(cur_in_ready), 32'd1);
    exp_q.delete();

    // Reset after four RUN steps discards the operation.
    a = 16'd200; b = 8'd3; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    check_eq("mid_rst_in_ready", 32'(cur_in_ready), 32'd1);
    check_eq("mid_rst_out_valid", 32'(cur_out_valid), 32'd0);
    check_eq("mid_rst_q", 32'(cur_q), 32'd0);
    check_eq("mid_rst_r", 32'(cur_r), 32'd0);
    check_eq("mid_rst_dbz", 32'(cur_dbz), 32'd0);
    do_op(16'd77, 8'd5, 0);

    for (int s = 0; s < 2; s++) begin
      sel = 2'(s);
      for (int i = 0; i < 500; i++) begin
        logic [15:0] ra;
        logic [7:0]  rb;
        ra = 16'($urandom);
        rb = ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom);
        do_op(ra, rb, 0);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/div_seq.md
# div_seq

Multi-cycle unsigned integer divider controller for the garbled-circuit datapath library. Instead of unrolling N subtract/select stages, it reuses one (M+1)-bit conditional-subtract stage and sequences it over N clock cycles, MSB first, with restoring division. Operands enter and results leave on valid/ready handshakes, so the block can sit between sequential producer and consumer stages. Quotient bits match the combinational divider already in the library for every operand pair, including divide-by-zero.

## Interface
- N, 8: dividend and quotient width; N ≥ 2
- M, N: divisor and remainder width; M ≥ 1
- clk  in  1  clock; all state changes on the rising edge
- rst  in  1  synchronous, active-low reset (0 = reset)
- in_valid  in  1  operands valid
- in_ready  out  1  block can accept operands
- a  in  N  dividend, unsigned
- b  in  M  divisor, unsigned
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts the result
- q  out  N  quotient
- r  out  M  remainder
- dbz  out  1  divide-by-zero flag (b == 0 at acceptance)

## Operation
- **States:** IDLE, RUN, DONE.
- **IDLE**
  - in_ready=1.
  - On in_valid&&in_ready:
    - latch a into shift register Q and b into D
    - clear R (M bits)
    - set cnt=N-1 and dbz=(b==0)
    - go to RUN.
- **RUN** (one step per cycle)
  - T = {R, Q[N-1]} is M+1 bits.
  - If T ≥ {1'b0,D}: R ← (T − D)[M-1:0], qbit=1. Otherwise R ← T[M-1:0], qbit=0.
  - Q ← {Q[N-2:0], qbit}.
  - If cnt==0, go to DONE. Otherwise decrement cnt.
- **DONE**
  - out_valid=1; q=Q, r=R.
  - On out_ready, go to IDLE.
- **Arithmetic**
  - The compare/subtract is M+1 bits wide, so no overflow is possible.
  - q = a / b and r = a % b for b ≠ 0.
- **Divide-by-zero**
  - No special path: every step subtracts 0, which gives q = all ones and r = the last M dividend bits shifted in. That is a[M-1:0] when N ≥ M, or a zero-extended when N < M.
  - dbz=1 accompanies the result.
- **Output stability**
  - q, r and dbz hold stable while out_valid=1 and out_ready=0.
  - In IDLE and RUN they are don't-care, but must not be X after reset.
- **Register count**
  - Sequential state is only: state, cnt (clog2(N) bits), Q, R, D, dbz.
  - No other storage.
- **Reset**
  - Applies in any state, including mid-RUN and DONE. An in-flight operation is discarded with no output produced.
  - Next cycle: state=IDLE, in_ready=1, out_valid=0, q=0, r=0, dbz=0, cnt=0.

## Timing
- Acceptance edge E0 (in_valid&&in_ready sampled high). RUN steps occur on edges E1..EN.
- out_valid=1 from the cycle after EN: N cycles after E0.
- Minimum back-to-back throughput is one op per N+2 cycles:
  - the DONE→IDLE handshake edge
  - the IDLE acceptance edge
  - N RUN edges.
- in_ready is 0 throughout RUN and DONE. in_valid is ignored there; the producer must hold its operands.
- in_ready and out_valid are registered-state decodes with no combinational path from in_valid or out_ready. Both are never 1 in the same cycle.
- out_ready while out_valid=0 has no effect.

## Test plan
- **Basic divide.** N=M=8; a=100, b=7 → out_valid exactly 8 cycles after accept; q=14, r=2, dbz=0.
- **Edge operands.** a=255, b=1 → q=255, r=0. a=5, b=9 → q=0, r=5. a=0, b=3 → q=0, r=0.
- **Divide-by-zero.** a=200, b=0 → q=255, r=200, dbz=1. With N=8, M=4: a=0xB7, b=0 → q=0xFF, r=0x7.
- **Backpressure and throughput.**
  - Hold out_ready=0 for 5 cycles after out_valid: q/r stable, in_ready=0, a new in_valid is not accepted.
  - Release: IDLE next cycle; a back-to-back op completes N+2 cycles after the previous completion.
- **Reset mid-operation.**
  - Drive rst=0 at RUN step 4: next cycle IDLE, in_ready=1, out_valid=0, q=r=0.
  - A following op a=77, b=5 gives q=15, r=2 with no residue from the aborted op.
- **Randomized sweep.** 1000 random (a, b) pairs, including b=0, for N=8, M=8 and N=16, M=8. Compare against a reference model of a/b, a%b and the divide-by-zero rule, and against the combinational divider's quotient.
